// File: rtl/bank_pkg.sv
// -----------------------------------------------------------------------------
// bank_pkg
//   Shared types and widths for the bank ISU -> SC issue path.
//   Holds the channel/opcode/payload widths, the opcode encoding, and the
//   isu_req_t record that describes one issued request. bank_isu reuses the
//   same record, so it is the single definition of an issue-slot payload.
// -----------------------------------------------------------------------------
package bank_pkg;

    localparam int NUM_CH = 4;   // requesting channels (power of two)
    localparam int CH_W   = 2;   // log2(NUM_CH)
    localparam int OP_W   = 2;   // opcode width
    localparam int SWO_W  = 7;   // set/way/offset width
    localparam int WBID_W = 8;   // write-buffer id width
    localparam int ROB_W  = 3;   // xbar ROB sequence number width

    // Every 2-bit code is named, so any value on an opcode bus maps to a member.
    typedef enum logic [OP_W-1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_EVICT = 2'd2,
        OP_FILL  = 2'd3
    } opcode_e;

    typedef struct packed {
        logic [CH_W-1:0]   ch_id;
        opcode_e           opcode;
        logic [SWO_W-1:0]  set_way_offset;
        logic [WBID_W-1:0] wbuffer_id;
        logic [ROB_W-1:0]  rob_num;
    } isu_req_t;

    // Sequence numbers wrap 2^ROB_W-1 -> 0 by plain modular increment.
    function automatic logic [ROB_W-1:0] rob_next(input logic [ROB_W-1:0] num);
        return num + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb
//   Purely combinational round-robin pick. Scans elig_i starting at rr_ptr_i
//   and wrapping modulo NUM_CH; the first set bit wins.
//   Ports:
//     elig_i       in   NUM_CH  per-channel eligibility
//     rr_ptr_i     in   CH_W    channel with highest priority this cycle
//     grant_o      out  NUM_CH  one-hot grant, zero when nothing is eligible
//     grant_idx_o  out  CH_W    index of the granted channel (0 when none)
//     any_grant_o  out  1       some channel was granted
// -----------------------------------------------------------------------------
module rr_arb #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] elig_i,
    input  logic [CH_W-1:0]   rr_ptr_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [CH_W-1:0]   grant_idx_o,
    output logic              any_grant_o
);

    logic [CH_W-1:0] scan_idx;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise paths that skip an assignment infer a latch.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        scan_idx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // NUM_CH is a power of two, so truncation to CH_W is the modulo.
            scan_idx = rr_ptr_i + CH_W'(i);
            if (!any_grant_o && elig_i[scan_idx]) begin
                any_grant_o       = 1'b1;
                grant_idx_o       = scan_idx;
                grant_o[scan_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bank_isu_arb.sv
// -----------------------------------------------------------------------------
// bank_isu_arb
//   Round-robin arbiter plus a single-entry issue register in front of the
//   bank ISU -> SC path. One channel request is accepted per cycle and lands
//   in the issue slot on the next edge, tagged with its source channel and a
//   wrapping ROB sequence number. A draining slot may be refilled in the same
//   cycle, so back-to-back issue runs at one per cycle.
//   Ports:
//     clk_i, rst_i                clock, synchronous active-high reset
//     cfg_ch_en_i                 per-channel enable mask
//     req_valid_i / req_ready_o   per-channel request handshake (ready one-hot)
//     req_opcode_i, req_set_way_offset_i, req_wbuffer_id_i
//                                 packed per-channel payload, channel c at [c*W +: W]
//     isu_sc_valid_o / isu_sc_ready_i
//                                 issue slot handshake toward SC
//     isu_sc_channel_id_o, isu_sc_opcode_o, isu_sc_set_way_offset_o,
//     isu_sc_wbuffer_id_o, isu_sc_xbar_rob_num_o
//                                 issue slot payload
//   req_ready_o is combinational from req_valid_i; requesters must not make
//   req_valid_i depend on req_ready_o.
// -----------------------------------------------------------------------------
module bank_isu_arb
    import bank_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_CH-1:0]        cfg_ch_en_i,
    input  logic [NUM_CH-1:0]        req_valid_i,
    output logic [NUM_CH-1:0]        req_ready_o,
    input  logic [NUM_CH*OP_W-1:0]   req_opcode_i,
    input  logic [NUM_CH*SWO_W-1:0]  req_set_way_offset_i,
    input  logic [NUM_CH*WBID_W-1:0] req_wbuffer_id_i,
    output logic                     isu_sc_valid_o,
    input  logic                     isu_sc_ready_i,
    output logic [CH_W-1:0]          isu_sc_channel_id_o,
    output logic [OP_W-1:0]          isu_sc_opcode_o,
    output logic [SWO_W-1:0]         isu_sc_set_way_offset_o,
    output logic [WBID_W-1:0]        isu_sc_wbuffer_id_o,
    output logic [ROB_W-1:0]         isu_sc_xbar_rob_num_o
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic              valid_q,   valid_d;
    isu_req_t          slot_q,    slot_d;
    logic [CH_W-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [ROB_W-1:0]  rob_cnt_q, rob_cnt_d;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] arb_grant;
    logic [CH_W-1:0]   arb_grant_idx;
    logic              arb_any;
    logic              load_en;
    logic              accept;

    assign elig = req_valid_i & cfg_ch_en_i;

    rr_arb #(
        .NUM_CH (NUM_CH)
    ) u_rr_arb (
        .elig_i      (elig),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_grant_idx),
        .any_grant_o (arb_any)
    );

    // The slot can take a new request when it is empty or draining this cycle.
    // Grants are suppressed while in reset so nothing is offered to requesters
    // that the reset edge would then throw away.
    assign load_en     = !valid_q || isu_sc_ready_i;
    assign accept      = load_en && arb_any && !rst_i;
    assign req_ready_o = accept ? arb_grant : '0;

    // -------------------------------------------------------------------------
    // Next-state
    // -------------------------------------------------------------------------
    always_comb begin
        valid_d   = valid_q;
        slot_d    = slot_q;
        rr_ptr_d  = rr_ptr_q;
        rob_cnt_d = rob_cnt_q;

        if (accept) begin
            // Replaces the slot even if it is draining this same cycle.
            valid_d               = 1'b1;
            slot_d.ch_id          = arb_grant_idx;
            slot_d.opcode         = opcode_e'(req_opcode_i[arb_grant_idx*OP_W +: OP_W]);
            slot_d.set_way_offset = req_set_way_offset_i[arb_grant_idx*SWO_W +: SWO_W];
            slot_d.wbuffer_id     = req_wbuffer_id_i[arb_grant_idx*WBID_W +: WBID_W];
            slot_d.rob_num        = rob_cnt_q;
            rr_ptr_d              = arb_grant_idx + 1'b1;
            rob_cnt_d             = rob_next(rob_cnt_q);
        end else if (valid_q && isu_sc_ready_i) begin
            // Drain with nothing to refill: payload keeps its last value.
            valid_d = 1'b0;
        end
        // Idle or stall: pointer and counter hold.
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            // NOTE: the slot payload is reset as well (it is only a few flops
            // and downstream sees defined zeros after reset); a pending slot
            // is simply dropped, never handshaken.
            slot_q    <= '0;
            rr_ptr_q  <= '0;
            rob_cnt_q <= '0;
        end else begin
            valid_q   <= valid_d;
            slot_q    <= slot_d;
            rr_ptr_q  <= rr_ptr_d;
            rob_cnt_q <= rob_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign isu_sc_valid_o          = valid_q;
    assign isu_sc_channel_id_o     = slot_q.ch_id;
    assign isu_sc_opcode_o         = slot_q.opcode;
    assign isu_sc_set_way_offset_o = slot_q.set_way_offset;
    assign isu_sc_wbuffer_id_o     = slot_q.wbuffer_id;
    assign isu_sc_xbar_rob_num_o   = slot_q.rob_num;

endmodule

// File: tb/tb_bank_isu_arb.sv
// -----------------------------------------------------------------------------
// tb_bank_isu_arb
//   Self-checking bench for bank_isu_arb. A behavioural model (plain ints and a
//   priority scan from the round-robin pointer) predicts req_ready_o and the
//   issue slot each cycle. Inputs change 1 time unit after the rising edge and
//   outputs are compared before the next edge.
// -----------------------------------------------------------------------------
module tb_bank_isu_arb;
    import bank_pkg::*;

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic [NUM_CH-1:0]        cfg_ch_en_i;
    logic [NUM_CH-1:0]        req_valid_i;
    logic [NUM_CH-1:0]        req_ready_o;
    logic [NUM_CH*OP_W-1:0]   req_opcode_i;
    logic [NUM_CH*SWO_W-1:0]  req_set_way_offset_i;
    logic [NUM_CH*WBID_W-1:0] req_wbuffer_id_i;
    logic                     isu_sc_valid_o;
    logic                     isu_sc_ready_i;
    logic [CH_W-1:0]          isu_sc_channel_id_o;
    logic [OP_W-1:0]          isu_sc_opcode_o;
    logic [SWO_W-1:0]         isu_sc_set_way_offset_o;
    logic [WBID_W-1:0]        isu_sc_wbuffer_id_o;
    logic [ROB_W-1:0]         isu_sc_xbar_rob_num_o;

    always #5 clk_i = ~clk_i;

    bank_isu_arb dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .cfg_ch_en_i             (cfg_ch_en_i),
        .req_valid_i             (req_valid_i),
        .req_ready_o             (req_ready_o),
        .req_opcode_i            (req_opcode_i),
        .req_set_way_offset_i    (req_set_way_offset_i),
        .req_wbuffer_id_i        (req_wbuffer_id_i),
        .isu_sc_valid_o          (isu_sc_valid_o),
        .isu_sc_ready_i          (isu_sc_ready_i),
        .isu_sc_channel_id_o     (isu_sc_channel_id_o),
        .isu_sc_opcode_o         (isu_sc_opcode_o),
        .isu_sc_set_way_offset_o (isu_sc_set_way_offset_o),
        .isu_sc_wbuffer_id_o     (isu_sc_wbuffer_id_o),
        .isu_sc_xbar_rob_num_o   (isu_sc_xbar_rob_num_o)
    );

    int n_checks = 0;
    int n_err    = 0;
    int hs_cnt   = 0;   // SC handshakes observed outside reset

    // Reference model state
    bit          m_valid = 1'b0;
    logic [1:0]  m_ch    = '0;
    logic [1:0]  m_op    = '0;
    logic [6:0]  m_swo   = '0;
    logic [7:0]  m_wbid  = '0;
    logic [2:0]  m_rob   = '0;
    int          m_ptr   = 0;
    int          m_cnt   = 0;

    // Which channel the model expects to be accepted right now (one-hot).
    function automatic logic [3:0] exp_ready();
        if (rst_i) return 4'b0000;
        if (m_valid && !isu_sc_ready_i) return 4'b0000;
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (req_valid_i[c] && cfg_ch_en_i[c]) return 4'(1 << c);
        end
        return 4'b0000;
    endfunction

    function automatic logic [21:0] exp_slot();
        return {m_ch, m_op, m_swo, m_wbid, m_rob};
    endfunction

    function automatic logic [21:0] dut_slot();
        return {isu_sc_channel_id_o, isu_sc_opcode_o, isu_sc_set_way_offset_o,
                isu_sc_wbuffer_id_o, isu_sc_xbar_rob_num_o};
    endfunction

    // Advance the model by one clock using the current inputs, then clock.
    task automatic tick();
        logic [3:0] r;
        int g;
        r = exp_ready();
        g = -1;
        for (int c = 0; c < 4; c++) if (r[c]) g = c;
        if (!rst_i && isu_sc_valid_o && isu_sc_ready_i) hs_cnt++;
        if (rst_i) begin
            m_valid = 1'b0;
            m_ch = '0; m_op = '0; m_swo = '0; m_wbid = '0; m_rob = '0;
            m_ptr = 0;
            m_cnt = 0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_ch    = 2'(g);
            m_op    = req_opcode_i[g*2 +: 2];
            m_swo   = req_set_way_offset_i[g*7 +: 7];
            m_wbid  = req_wbuffer_id_i[g*8 +: 8];
            m_rob   = 3'(m_cnt);
            m_ptr   = (g + 1) % 4;
            m_cnt   = (m_cnt + 1) % 8;
        end else if (m_valid && isu_sc_ready_i) begin
            m_valid = 1'b0;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic rnd_payload();
        req_opcode_i         = 8'($urandom);
        req_set_way_offset_i = 28'($urandom);
        req_wbuffer_id_i     = $urandom;
    endtask

    task automatic do_reset();
        rst_i          = 1'b1;
        req_valid_i    = '0;
        cfg_ch_en_i    = 4'hF;
        isu_sc_ready_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst_i          = 1'b1;
        req_valid_i    = 4'hF;
        cfg_ch_en_i    = 4'hF;
        isu_sc_ready_i = 1'b1;
        rnd_payload();
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (isu_sc_valid_o !== 1'b0) begin
                n_err++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", i, isu_sc_valid_o);
            end
            n_checks++;
            if (req_ready_o !== 4'b0000) begin
                n_err++; $display("FAIL reset_ready cyc=%0d got=%b exp=0000", i, req_ready_o);
            end
            n_checks++;
            if (dut_slot() !== 22'd0) begin
                n_err++; $display("FAIL reset_payload cyc=%0d got=%h exp=0", i, dut_slot());
            end
        end
        rst_i = 1'b0;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0001) begin
            n_err++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready_o);
        end
        tick();
        n_checks++;
        if ({isu_sc_valid_o, isu_sc_channel_id_o, isu_sc_xbar_rob_num_o} !== {1'b1, 2'd0, 3'd0}) begin
            n_err++;
            $display("FAIL reset_first_slot got v=%b ch=%0d rob=%0d exp v=1 ch=0 rob=0",
                     isu_sc_valid_o, isu_sc_channel_id_o, isu_sc_xbar_rob_num_o);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_round_robin();
        do_reset();
        req_valid_i = 4'hF;
        for (int i = 0; i < 10; i++) begin
            rnd_payload();
            #1;
            n_checks++;
            if (req_ready_o !== 4'(1 << (i % 4))) begin
                n_err++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", i, req_ready_o, 4'(1 << (i % 4)));
            end
            tick();
            n_checks++;
            if ({isu_sc_valid_o, isu_sc_channel_id_o, isu_sc_xbar_rob_num_o} !== {1'b1, 2'(i % 4), 3'(i % 8)}) begin
                n_err++;
                $display("FAIL rr_order cyc=%0d got v=%b ch=%0d rob=%0d exp v=1 ch=%0d rob=%0d", i,
                         isu_sc_valid_o, isu_sc_channel_id_o, isu_sc_xbar_rob_num_o, i % 4, i % 8);
            end
            n_checks++;
            if (dut_slot() !== exp_slot()) begin
                n_err++; $display("FAIL rr_payload cyc=%0d got=%h exp=%h", i, dut_slot(), exp_slot());
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_backpressure();
        int hs0;
        do_reset();
        req_valid_i = 4'b0100;
        rnd_payload();
        req_opcode_i[4 +: 2]          = 2'b01;
        req_set_way_offset_i[14 +: 7] = 7'h15;
        req_wbuffer_id_i[16 +: 8]     = 8'hA5;
        #1;
        tick();
        isu_sc_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rnd_payload();   // ch2 payload changes too; the slot must not follow
            #1;
            n_checks++;
            if (req_ready_o !== 4'b0000) begin
                n_err++; $display("FAIL bp_ready cyc=%0d got=%b exp=0000", i, req_ready_o);
            end
            n_checks++;
            if ({isu_sc_valid_o, dut_slot()} !== {1'b1, 2'd2, 2'b01, 7'h15, 8'hA5, 3'd0}) begin
                n_err++; $display("FAIL bp_hold cyc=%0d got v=%b slot=%h exp v=1 slot=%h", i,
                                  isu_sc_valid_o, dut_slot(), {2'd2, 2'b01, 7'h15, 8'hA5, 3'd0});
            end
            tick();
        end
        isu_sc_ready_i                = 1'b1;
        req_opcode_i[4 +: 2]          = 2'b10;
        req_set_way_offset_i[14 +: 7] = 7'h2A;
        req_wbuffer_id_i[16 +: 8]     = 8'h5A;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0100) begin
            n_err++; $display("FAIL bp_release_ready got=%b exp=0100", req_ready_o);
        end
        hs0 = hs_cnt;
        tick();
        n_checks++;
        if ({isu_sc_valid_o, dut_slot()} !== {1'b1, 2'd2, 2'b10, 7'h2A, 8'h5A, 3'd1}) begin
            n_err++; $display("FAIL bp_reload got v=%b slot=%h exp v=1 slot=%h",
                              isu_sc_valid_o, dut_slot(), {2'd2, 2'b10, 7'h2A, 8'h5A, 3'd1});
        end
        n_checks++;
        if (hs_cnt !== hs0 + 1) begin
            n_err++; $display("FAIL bp_handshake got=%0d exp=%0d", hs_cnt - hs0, 1);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_enable_mask();
        do_reset();
        cfg_ch_en_i = 4'b1010;
        req_valid_i = 4'hF;
        for (int i = 0; i < 8; i++) begin
            rnd_payload();
            #1;
            n_checks++;
            if (req_ready_o !== exp_ready()) begin
                n_err++; $display("FAIL mask_ready cyc=%0d got=%b exp=%b", i, req_ready_o, exp_ready());
            end
            n_checks++;
            if ((req_ready_o & 4'b0101) !== 4'b0000) begin
                n_err++; $display("FAIL mask_disabled cyc=%0d got=%b exp=x0x0", i, req_ready_o);
            end
            tick();
            n_checks++;
            if (isu_sc_channel_id_o !== ((i % 2 == 0) ? 2'd1 : 2'd3)) begin
                n_err++; $display("FAIL mask_order cyc=%0d got=%0d exp=%0d", i,
                                  isu_sc_channel_id_o, (i % 2 == 0) ? 1 : 3);
            end
            n_checks++;
            if (dut_slot() !== exp_slot()) begin
                n_err++; $display("FAIL mask_payload cyc=%0d got=%h exp=%h", i, dut_slot(), exp_slot());
            end
        end
        cfg_ch_en_i = 4'hF;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_pointer_hold();
        do_reset();
        req_valid_i = 4'b0010;
        rnd_payload();
        #1;
        tick();
        req_valid_i = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (req_ready_o !== 4'b0000) begin
                n_err++; $display("FAIL hold_idle_ready cyc=%0d got=%b exp=0000", i, req_ready_o);
            end
            tick();
            n_checks++;
            if ({isu_sc_valid_o, isu_sc_channel_id_o} !== {1'b0, 2'd1}) begin
                n_err++; $display("FAIL hold_drain cyc=%0d got v=%b ch=%0d exp v=0 ch=1", i,
                                  isu_sc_valid_o, isu_sc_channel_id_o);
            end
        end
        req_valid_i = 4'b1001;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b1000) begin
            n_err++; $display("FAIL hold_first got=%b exp=1000", req_ready_o);
        end
        tick();
        n_checks++;
        if (isu_sc_channel_id_o !== 2'd3) begin
            n_err++; $display("FAIL hold_first_slot got=%0d exp=3", isu_sc_channel_id_o);
        end
        n_checks++;
        if (req_ready_o !== 4'b0001) begin
            n_err++; $display("FAIL hold_second got=%b exp=0001", req_ready_o);
        end
        tick();
        n_checks++;
        if (isu_sc_channel_id_o !== 2'd0) begin
            n_err++; $display("FAIL hold_second_slot got=%0d exp=0", isu_sc_channel_id_o);
        end
        req_valid_i = 4'b0000;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_stall();
        int hs0;
        do_reset();
        req_valid_i = 4'b0001;
        rnd_payload();
        #1;
        tick();
        req_valid_i    = 4'b0000;
        isu_sc_ready_i = 1'b0;
        tick();
        tick();
        n_checks++;
        if (isu_sc_valid_o !== 1'b1) begin
            n_err++; $display("FAIL mrst_stall got=%b exp=1", isu_sc_valid_o);
        end
        hs0   = hs_cnt;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_checks++;
        if ({isu_sc_valid_o, dut_slot()} !== 23'd0) begin
            n_err++; $display("FAIL mrst_cleared got v=%b slot=%h exp v=0 slot=0", isu_sc_valid_o, dut_slot());
        end
        isu_sc_ready_i = 1'b1;
        tick();
        n_checks++;
        if (hs_cnt !== hs0) begin
            n_err++; $display("FAIL mrst_no_handshake got=%0d exp=0", hs_cnt - hs0);
        end
        req_valid_i = 4'b0100;
        rnd_payload();
        #1;
        tick();
        n_checks++;
        if ({isu_sc_valid_o, isu_sc_channel_id_o, isu_sc_xbar_rob_num_o} !== {1'b1, 2'd2, 3'd0}) begin
            n_err++; $display("FAIL mrst_rob_restart got v=%b ch=%0d rob=%0d exp v=1 ch=2 rob=0",
                              isu_sc_valid_o, isu_sc_channel_id_o, isu_sc_xbar_rob_num_o);
        end
        n_checks++;
        if (dut_slot() !== exp_slot()) begin
            n_err++; $display("FAIL mrst_payload got=%h exp=%h", dut_slot(), exp_slot());
        end
        req_valid_i = 4'b0000;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_valid_i    = 4'($urandom);
            cfg_ch_en_i    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            isu_sc_ready_i = ($urandom_range(0, 3) != 0);
            rst_i          = ($urandom_range(0, 63) == 0);
            rnd_payload();
            #1;
            n_checks++;
            if (req_ready_o !== exp_ready()) begin
                n_err++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, req_ready_o, exp_ready());
            end
            tick();
            n_checks++;
            if ({isu_sc_valid_o, dut_slot()} !== {m_valid, exp_slot()}) begin
                n_err++; $display("FAIL rand_slot cyc=%0d got v=%b slot=%h exp v=%b slot=%h", i,
                                  isu_sc_valid_o, dut_slot(), m_valid, exp_slot());
            end
        end
        rst_i = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    initial begin
        rst_i                = 1'b1;
        cfg_ch_en_i          = 4'hF;
        req_valid_i          = '0;
        isu_sc_ready_i       = 1'b1;
        req_opcode_i         = '0;
        req_set_way_offset_i = '0;
        req_wbuffer_id_i     = '0;
        #1;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_enable_mask();
        test_pointer_hold();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
